// File: rtl/jtdd_objscan_if.sv
// Object scanner bus: object RAM read port, line timing inputs and the
// request/busy handshake towards jtframe_objdraw.
// master = scanner side, slave = RAM/drawer/timing side.
interface jtdd_objscan_if #(
    parameter int AW = 9,
    parameter int CW = 13,
    parameter int PW = 4
);
    logic          hbl;
    logic [7:0]    vpos;
    logic [AW-1:0] oram_addr;
    logic [7:0]    oram_data;
    logic          draw;
    logic          dr_busy;
    logic [CW-1:0] code;
    logic [8:0]    xpos;
    logic [3:0]    ysub;
    logic          hflip;
    logic          vflip;
    logic [PW-1:0] pal;
    logic          line_full;

    modport master (
        input  hbl, vpos, oram_data, dr_busy,
        output oram_addr, draw, code, xpos, ysub, hflip, vflip, pal, line_full
    );

    modport slave (
        output hbl, vpos, oram_data, dr_busy,
        input  oram_addr, draw, code, xpos, ysub, hflip, vflip, pal, line_full
    );
endinterface

// File: rtl/jtdd_objscan.sv
// jtdd_objscan: walks the object table once per line (started by the HBL
// falling edge), keeps the entries that hit the line and hands one request
// per hit to an external jtframe_objdraw.
// Build option: JTDD_OBJSCAN_REVERSE_EN scans entries from ENTRIES-1 down
// to 0 instead of 0 up to ENTRIES-1; timing is otherwise identical.
module jtdd_objscan #(
    parameter int AW      = 9,
    parameter int ENTRIES = 102,
    parameter int EB      = 5,
    parameter int MAXOBJ  = 32,
    parameter int CW      = 13,
    parameter int PW      = 4
)(
    input  logic           clk,
    input  logic           rst,
    jtdd_objscan_if.master bus
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

`ifdef JTDD_OBJSCAN_REVERSE_EN
    localparam logic          DOWN       = 1'b1;
    localparam logic [IW-1:0] IDX_FIRST  = IW'(ENTRIES - 1);
    localparam logic [IW-1:0] IDX_LAST   = '0;
    localparam logic [AW-1:0] BASE_FIRST = AW'((ENTRIES - 1) * EB);
`else
    localparam logic          DOWN       = 1'b0;
    localparam logic [IW-1:0] IDX_FIRST  = '0;
    localparam logic [IW-1:0] IDX_LAST   = IW'(ENTRIES - 1);
    localparam logic [AW-1:0] BASE_FIRST = '0;
`endif

    typedef enum logic [2:0] {IDLE, RDY, RDA, RD2, RD3, RD4, ISSUE, WAIT} state_t;

    state_t        state_q, state_d;
    logic          ph_q, ph_d;          // 0: address out, 1: capture data
    logic [IW-1:0] idx_q, idx_d, idx_nx;
    logic [AW-1:0] base_q, base_d, base_nx;
    logic [7:0]    cnt_q, cnt_d, cnt_inc;
    logic          full_q, full_d;
    logic [7:0]    vpos_q, vpos_d;
    logic [7:0]    y_q, y_d;
    logic [5:1]    attr_q, attr_d;      // only the attr bits needed after the hit test
    logic [7:0]    attr2_q, attr2_d;
    logic [7:0]    id_q, id_d;
    logic [CW-1:0] code_q, code_d;
    logic [8:0]    xpos_q, xpos_d;
    logic [3:0]    ysub_q, ysub_d;
    logic          hflip_q, hflip_d;
    logic          vflip_q, vflip_d;
    logic [PW-1:0] pal_q, pal_d;
    logic          hbl_q, hbl_fall;
    logic          step;
    logic [8:0]    rel;
    logic          hit;
    logic [3:0]    row_mask, row;
    logic [2:0]    addr_off;

    // rel[7:4] bits that must all be ones for a hit; size code 3 acts as 2
    function automatic logic [3:0] top_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    top_mask = 4'b1111;
            2'd1:    top_mask = 4'b1110;
            default: top_mask = 4'b1100;
        endcase
    endfunction

    assign hbl_fall = hbl_q & ~bus.hbl;
    assign idx_nx   = DOWN ? idx_q - IW'(1) : idx_q + IW'(1);
    assign base_nx  = DOWN ? base_q - AW'(EB) : base_q + AW'(EB);
    assign cnt_inc  = cnt_q + 8'd1;

    // Hit test runs while attr is on the data bus; row uses the stored attr
    assign rel      = {1'b0, vpos_q} + {1'b0, y_q};
    assign hit      = bus.oram_data[7] && (rel[8] == bus.oram_data[0]) &&
                      ((rel[7:4] | ~top_mask(bus.oram_data[5:4])) == 4'hF);
    assign row_mask = ~top_mask(attr_q[5:4]);
    assign row      = (attr_q[2] ? ~rel[7:4] : rel[7:4]) & row_mask;

    // Object RAM address: entry base plus the byte offset of the read state
    always_comb begin
        addr_off = '0;
        case (state_q)
            RDA:     addr_off = 3'd1;
            RD2:     addr_off = 3'd2;
            RD3:     addr_off = 3'd3;
            RD4:     addr_off = 3'd4;
            default: addr_off = '0;
        endcase
        bus.oram_addr = (state_q == IDLE) ? '0 : base_q + AW'(addr_off);
    end

    assign bus.draw      = (state_q == ISSUE);
    assign bus.code      = code_q;
    assign bus.xpos      = xpos_q;
    assign bus.ysub      = ysub_q;
    assign bus.hflip     = hflip_q;
    assign bus.vflip     = vflip_q;
    assign bus.pal       = pal_q;
    assign bus.line_full = full_q;

    // Next state: HBL fall restarts from any state, otherwise walk the entry
    always_comb begin
        state_d = state_q;
        ph_d    = 1'b0;
        idx_d   = idx_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        vpos_d  = vpos_q;
        y_d     = y_q;
        attr_d  = attr_q;
        attr2_d = attr2_q;
        id_d    = id_q;
        code_d  = code_q;
        xpos_d  = xpos_q;
        ysub_d  = ysub_q;
        hflip_d = hflip_q;
        vflip_d = vflip_q;
        pal_d   = pal_q;
        step    = 1'b0;
        if (hbl_fall) begin
            state_d = RDY;
            idx_d   = IDX_FIRST;
            base_d  = BASE_FIRST;
            cnt_d   = '0;
            full_d  = 1'b0;
            vpos_d  = bus.vpos;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                RDY: begin
                    if (!ph_q) ph_d = 1'b1;
                    else begin
                        y_d     = bus.oram_data;
                        state_d = RDA;
                    end
                end
                RDA: begin
                    if (!ph_q) ph_d = 1'b1;
                    else if (hit) begin
                        attr_d  = bus.oram_data[5:1];
                        state_d = RD2;
                    end else step = 1'b1;
                end
                RD2: begin
                    if (!ph_q) ph_d = 1'b1;
                    else begin
                        attr2_d = bus.oram_data;
                        state_d = RD3;
                    end
                end
                RD3: begin
                    if (!ph_q) ph_d = 1'b1;
                    else begin
                        id_d    = bus.oram_data;
                        state_d = RD4;
                    end
                end
                RD4: begin
                    if (!ph_q) ph_d = 1'b1;
                    else begin
                        // request fields load on the edge that enters ISSUE
                        code_d  = {(CW-8)'(attr2_q & (8'hFF >> PW)), id_q + {4'b0000, row}};
                        xpos_d  = {attr_q[1], bus.oram_data};
                        ysub_d  = rel[3:0];
                        hflip_d = ~attr_q[3];
                        vflip_d = attr_q[2];
                        pal_d   = attr2_q[7 -: PW];
                        state_d = ISSUE;
                    end
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    if (!bus.dr_busy) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == 8'(MAXOBJ)) begin
                            full_d  = 1'b1;
                            state_d = IDLE;
                        end else step = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (step) begin
                if (idx_q == IDX_LAST) state_d = IDLE;
                else begin
                    idx_d   = idx_nx;
                    base_d  = base_nx;
                    state_d = RDY;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            vpos_q  <= '0;
            y_q     <= '0;
            attr_q  <= '0;
            attr2_q <= '0;
            id_q    <= '0;
            code_q  <= '0;
            xpos_q  <= '0;
            ysub_q  <= '0;
            hflip_q <= 1'b0;
            vflip_q <= 1'b0;
            pal_q   <= '0;
            hbl_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            vpos_q  <= vpos_d;
            y_q     <= y_d;
            attr_q  <= attr_d;
            attr2_q <= attr2_d;
            id_q    <= id_d;
            code_q  <= code_d;
            xpos_q  <= xpos_d;
            ysub_q  <= ysub_d;
            hflip_q <= hflip_d;
            vflip_q <= vflip_d;
            pal_q   <= pal_d;
            hbl_q   <= bus.hbl;
        end
    end
endmodule

// File: tb/tb_jtdd_objscan.sv
// Scoreboard bench for jtdd_objscan: per line, a reference model fills a
// queue of expected draw requests; a negedge monitor pops and compares.
module tb_jtdd_objscan;
    localparam int AW      = 9;
    localparam int ENTRIES = 102;
    localparam int EB      = 5;
    localparam int MAXOBJ  = 32;
    localparam int CW      = 13;
    localparam int PW      = 4;
`ifdef JTDD_OBJSCAN_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] code;
        logic [8:0]    xpos;
        logic [3:0]    ysub;
        logic          hflip;
        logic          vflip;
        logic [PW-1:0] pal;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jtdd_objscan_if #(.AW(AW), .CW(CW), .PW(PW)) bus ();

    jtdd_objscan #(
        .AW(AW), .ENTRIES(ENTRIES), .EB(EB), .MAXOBJ(MAXOBJ), .CW(CW), .PW(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] mem [0:(1<<AW)-1];
    int   busy_len = 0;
    int   busy_cnt;
    int   errors = 0;
    int   checks = 0;
    int   draws_seen = 0;
    logic prev_busy = 1'b0;
    exp_t expq [$];

    // synchronous object RAM: data one clock after the address
    always @(posedge clk) bus.oram_data <= mem[bus.oram_addr];

    // drawer: busy for busy_len clocks after each request
    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 0;
        else if (bus.draw) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.dr_busy = (busy_cnt != 0);

    // monitor: every draw strobe is compared with the head of the queue
    always @(negedge clk) begin
        exp_t e, g;
        if (!rst && bus.draw) begin
            draws_seen++;
            g.code = bus.code; g.xpos = bus.xpos; g.ysub = bus.ysub;
            g.hflip = bus.hflip; g.vflip = bus.vflip; g.pal = bus.pal;
            checks++;
            if (prev_busy) begin
                errors++;
                $display("FAIL busy_gap: dr_busy before draw got 1, required 0");
            end
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_draw: got code=%h xpos=%h, required no draw", g.code, g.xpos);
            end else begin
                e = expq.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL draw_fields: got code=%h xpos=%h ysub=%h hf=%b vf=%b pal=%h, required code=%h xpos=%h ysub=%h hf=%b vf=%b pal=%h",
                             g.code, g.xpos, g.ysub, g.hflip, g.vflip, g.pal,
                             e.code, e.xpos, e.ysub, e.hflip, e.vflip, e.pal);
                end
            end
        end
        prev_busy = bus.dr_busy;
    end

    function automatic int scan_idx(input int k);
        return REV ? ENTRIES - 1 - k : k;
    endfunction

    // reference model: hit when (vpos+y) lands in the last h rows of its 256 window
    task automatic build_expect(input logic [7:0] v, output bit full);
        int cnt, b, y, a, a2, id, x, sz, h, rel, row;
        exp_t e;
        cnt = 0;
        for (int k = 0; k < ENTRIES; k++) begin
            b  = scan_idx(k) * EB;
            y  = int'(mem[b]);
            a  = int'(mem[b+1]);
            a2 = int'(mem[b+2]);
            id = int'(mem[b+3]);
            x  = int'(mem[b+4]);
            sz = (a >> 4) & 3;
            if (sz == 3) sz = 2;
            h   = 16 << sz;
            rel = int'(v) + y;
            if (cnt < MAXOBJ && (a & 128) != 0 && (rel / 256) == (a & 1) && (rel % 256) >= 256 - h) begin
                row = ((rel % 256) % h) / 16;
                if ((a & 4) != 0) row = h / 16 - 1 - row;
                e.code  = CW'(((a2 % (256 >> PW)) << 8) + ((id + row) % 256));
                e.xpos  = 9'(((a >> 1) & 1) * 256 + x);
                e.ysub  = 4'(rel % 16);
                e.hflip = ((a & 8) == 0);
                e.vflip = ((a & 4) != 0);
                e.pal   = PW'(a2 >> (8 - PW));
                expq.push_back(e);
                cnt++;
            end
        end
        full = (cnt == MAXOBJ);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    endtask

    task automatic set_entry(input int n, input logic [7:0] y, a, a2, id, x);
        mem[n*EB]   = y;
        mem[n*EB+1] = a;
        mem[n*EB+2] = a2;
        mem[n*EB+3] = id;
        mem[n*EB+4] = x;
    endtask

    // random enabled entry placed so that it hits line v
    task automatic make_hit(input int n, input logic [7:0] v);
        logic [7:0] a;
        int sz, h, t, y;
        a  = 8'($urandom) | 8'h80;
        sz = (a[5:4] == 2'd3) ? 2 : int'(a[5:4]);
        h  = 16 << sz;
        t  = 256 - h + int'($urandom_range(0, h - 1));
        y  = (t - int'(v)) & 255;
        a[0] = ((int'(v) + y) >= 256);
        set_entry(n, 8'(y), a, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic fill_random(input logic [7:0] v);
        for (int n = 0; n < ENTRIES; n++) begin
            case ($urandom_range(0, 2))
                0: set_entry(n, 8'($urandom), 8'($urandom) & 8'h7F, 8'($urandom), 8'($urandom), 8'($urandom));
                1: set_entry(n, 8'($urandom), 8'($urandom) | 8'h80, 8'($urandom), 8'($urandom), 8'($urandom));
                default: make_hit(n, v);
            endcase
        end
    endtask

    task automatic finish_line(input bit full, input string tag);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s drain: got %0d draws missing, required 0", tag, expq.size());
            expq.delete();
        end
        checks++;
        if (bus.line_full !== full) begin
            errors++;
            $display("FAIL %s line_full: got %b, required %b", tag, bus.line_full, full);
        end
        checks++;
        if (bus.oram_addr !== '0 || bus.draw !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: got addr=%h draw=%b, required 0/0", tag, bus.oram_addr, bus.draw);
        end
    endtask

    task automatic start_line(input logic [7:0] v, input int bl, output bit full);
        busy_len = bl;
        @(posedge clk); #1;
        bus.hbl  = 1'b1;
        bus.vpos = v;
        repeat (3) @(posedge clk);
        build_expect(v, full);
        #1 bus.hbl = 1'b0;
    endtask

    task automatic run_line(input logic [7:0] v, input int bl, input string tag);
        bit full;
        start_line(v, bl, full);
        repeat (ENTRIES * 4 + MAXOBJ * (14 + bl) + 40) @(posedge clk);
        #1 finish_line(full, tag);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({bus.oram_addr, bus.draw, bus.code, bus.xpos, bus.ysub, bus.hflip,
             bus.vflip, bus.pal, bus.line_full} !== '0) begin
            errors++;
            $display("FAIL %s: got addr=%h draw=%b code=%h xpos=%h ysub=%h hf=%b vf=%b pal=%h full=%b, required all 0",
                     tag, bus.oram_addr, bus.draw, bus.code, bus.xpos, bus.ysub,
                     bus.hflip, bus.vflip, bus.pal, bus.line_full);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int  first, snap;
        bit  found, full;
        logic [7:0] v;
        first    = scan_idx(0);
        rst      = 1'b1;
        bus.hbl  = 1'b0;
        bus.vpos = 8'h00;
        clear_mem();
        repeat (3) @(posedge clk);
        #1 check_zero("reset_state");
        rst = 1'b0;

        // documented vectors (model decides whether each one hits)
        set_entry(first, 8'hF0, 8'h80, 8'h12, 8'h34, 8'h56);
        run_line(8'h10, 0, "vec1");
        clear_mem();
        set_entry(first, 8'hC0, 8'hA4, 8'h12, 8'h34, 8'h56);
        run_line(8'h15, 0, "vec2");

        // randomized tables
        for (int l = 0; l < 10; l++) begin
            v = 8'($urandom);
            fill_random(v);
            run_line(v, int'($urandom_range(0, 3)), "rand");
        end

        // every entry hits: capped at MAXOBJ
        v = 8'($urandom);
        for (int n = 0; n < ENTRIES; n++) make_hit(n, v);
        run_line(v, int'($urandom_range(0, 3)), "all_hit");

        // exactly MAXOBJ hits ending on the last scanned entry, then MAXOBJ-1
        clear_mem();
        v = 8'($urandom);
        for (int k = ENTRIES - MAXOBJ; k < ENTRIES; k++) make_hit(scan_idx(k), v);
        run_line(v, 1, "cap_last");
        clear_mem();
        for (int k = ENTRIES - MAXOBJ + 1; k < ENTRIES; k++) make_hit(scan_idx(k), v);
        run_line(v, 0, "cap_minus1");

        // drawer busy for 50 clocks after each request
        clear_mem();
        v = 8'h40;
        make_hit(first, v);
        make_hit(scan_idx(1), v);
        make_hit(scan_idx(5), v);
        run_line(v, 50, "busy50");

        // abort in RD3 of the first entry; restart with a new line
        clear_mem();
        set_entry(first, 8'hC0, 8'hA4, 8'h12, 8'h34, 8'h56);
        busy_len = 0;
        @(posedge clk); #1;
        bus.hbl  = 1'b1;
        bus.vpos = 8'h15;
        repeat (3) @(posedge clk);
        #1 bus.hbl = 1'b0;
        @(posedge clk); #1 bus.hbl = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.oram_addr == AW'(first * EB + 3)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach: got no RD3 address within 60 clk, required it");
        end
        bus.vpos = 8'h25;
        build_expect(8'h25, full);
        bus.hbl = 1'b0;
        repeat (ENTRIES * 4 + MAXOBJ * 14 + 40) @(posedge clk);
        #1 finish_line(full, "abort");

        // reset while waiting on the drawer
        clear_mem();
        make_hit(first, 8'h33);
        make_hit(scan_idx(1), 8'h33);
        start_line(8'h33, 50, full);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.draw) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_wait_draw: got no draw within 200 clk, required one");
        end
        @(posedge clk); #2 rst = 1'b1;
        #1 check_zero("rst_in_wait");
        expq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        snap = draws_seen;
        repeat (300) @(posedge clk);
        checks++;
        if (draws_seen != snap) begin
            errors++;
            $display("FAIL rst_no_draw: got %0d draws after reset, required 0", draws_seen - snap);
        end
        fill_random(8'h77);
        run_line(8'h77, 2, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
